updown_tick_counter: RTL
========================

Name: updown_tick_counter

Overview:
- Parametrised up/down event counter with a built-in tick prescaler. It runs entirely in the system clock domain and advances on a one-cycle clock-enable, not on a derived clock.
- Successor to the fixed 0..21 timer counter used by the microwave music/timing path.
- Adds configurable width and limit, saturate or wrap mode, parallel load, and boundary flags. It also produces a terminal-count pulse for the sequencing logic.

Parameters:
- WIDTH, 8, count register width in bits.
- MAX_COUNT, 21, upper count limit; must satisfy 1 <= MAX_COUNT <= 2**WIDTH-1.
- DIV, 50000000, system clocks per count tick; must be >= 1.
- DIV_W, 26, prescaler width; must satisfy 2**DIV_W >= DIV.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- activado  input  1  run enable; low clears the count and the prescaler.
- updown  input  1  direction: 1 = count up, 0 = count down.
- wrap_mode  input  1  limit behaviour: 0 = saturate, 1 = wrap around.
- load  input  1  one-cycle parallel load strobe.
- load_value  input  WIDTH  value captured when load is high.
- out  output  WIDTH  current count, registered.
- tick  output  1  registered one-cycle pulse marking each count step opportunity.
- at_max  output  1  combinational flag, high when out == MAX_COUNT.
- at_zero  output  1  combinational flag, high when out == 0.
- tc  output  1  registered one-cycle terminal-count pulse.

Behaviour:
- Single clock domain. Reset is synchronous and active-low on rst_n, and clk is the only clock.
- Reset values: out=0, prescaler=0, tick=0, tc=0. The flags at_zero=1 and at_max=0 follow from out=0.
- Priority per cycle, highest first: rst_n low, then activado low, then load, then step.
- activado low:
  - out <= 0, prescaler <= 0, tick <= 0, tc <= 0.
  - load is ignored while activado is low.
- load high with activado high:
  - out <= min(load_value, MAX_COUNT).
  - prescaler <= 0.
  - tick <= 0, tc <= 0, and no step is taken that cycle.
- Prescaler:
  - Counts 0..DIV-1 while activado is high and load is low.
  - When the prescaler equals DIV-1 it goes back to 0, and a step is taken in the same cycle.
  - tick is high in the cycle after that step, together with the updated out.
  - With DIV=1 a step happens every cycle and tick stays high.
- Step with updown=1:
  - If out < MAX_COUNT, out <= out+1.
  - Else, with wrap_mode=0 out holds; with wrap_mode=1 out <= 0.
- Step with updown=0:
  - If out > 0, out <= out-1.
  - Else, with wrap_mode=0 out holds; with wrap_mode=1 out <= MAX_COUNT.
- tc is high for exactly one cycle, aligned with tick, when a step either:
  - moves out onto its boundary (up reaching MAX_COUNT, down reaching 0), or
  - performs a wrap.
- tc is not asserted when:
  - a saturated hold keeps out at the boundary, or
  - a load places out on a boundary.
- Direction or mode changes take effect at the next step; the prescaler phase is not disturbed.
- Out-of-range state: if out > MAX_COUNT, which is reachable only through a parameter change, the next up step behaves as if out == MAX_COUNT. The next down step decrements normally.
- Arithmetic is unsigned at WIDTH bits, and no intermediate value exceeds WIDTH bits.

Optional Feature:
- Macro: UPDOWN_TICK_COUNTER_PAUSE_EN.
- Defined:
  - Adds input port pausa (1 bit).
  - While pausa=1 and activado=1: prescaler and out freeze, and tick=0, tc=0.
  - load still has priority over pausa.
  - activado low still clears everything.
- Not defined: the port does not exist and behaviour is exactly as above.

Test Plan:
- Reset: DIV=4, MAX_COUNT=21; hold rst_n=0 with activado=1 for 3 cycles -> out=0, tick=0, tc=0, at_zero=1.
- Saturate up: activado=1, updown=1, wrap_mode=0, from 0 -> out increments every 4 clocks; tc pulses once when out becomes 21; out holds at 21 with no further tc, while tick keeps pulsing every 4 clocks.
- Wrap down: load_value=1, then updown=0, wrap_mode=1 -> out goes 1, 0 (tc), then 21 (tc, wrap), then 20.
- Load clamp and priority: load=1 with load_value=200 -> out=21, prescaler restarts, the next tick comes 4 clocks later; activado=0 with load=1 in the same cycle -> out=0.
- Mid-run disable: activado dropped at count 9 partway through a prescaler period -> out=0 the next cycle; re-enable gives the first tick exactly DIV clocks later.
- Pause, macro defined: pausa=1 for 10 clocks at out=5 -> out stays 5 with no tick; after release, the remaining prescaler phase completes before the next step.

Source files
------------

// File: rtl/updown_tick_counter_if.sv
// Control/status bundle for updown_tick_counter; master drives controls, slave is the counter.
// Carries the pausa line only when UPDOWN_TICK_COUNTER_PAUSE_EN is defined.
interface updown_tick_counter_if #(
    parameter int WIDTH = 8
);
    logic             activado;
    logic             updown;
    logic             wrap_mode;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] out;
    logic             tick;
    logic             at_max;
    logic             at_zero;
    logic             tc;
`ifdef UPDOWN_TICK_COUNTER_PAUSE_EN
    logic             pausa;

    modport master (
        output activado, updown, wrap_mode, load, load_value, pausa,
        input  out, tick, at_max, at_zero, tc
    );
    modport slave (
        input  activado, updown, wrap_mode, load, load_value, pausa,
        output out, tick, at_max, at_zero, tc
    );
`else
    modport master (
        output activado, updown, wrap_mode, load, load_value,
        input  out, tick, at_max, at_zero, tc
    );
    modport slave (
        input  activado, updown, wrap_mode, load, load_value,
        output out, tick, at_max, at_zero, tc
    );
`endif
endinterface

// File: rtl/updown_tick_counter.sv
// Up/down event counter stepped by an internal prescaler clock-enable, with saturate/wrap,
// clamped parallel load and boundary flags. Optional pause input: UPDOWN_TICK_COUNTER_PAUSE_EN.
module updown_tick_counter #(
    parameter int WIDTH     = 8,
    parameter int MAX_COUNT = 21,
    parameter int DIV       = 50000000,
    parameter int DIV_W     = 26
) (
    input  logic                  clk,
    input  logic                  rst_n,
    updown_tick_counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] MAX_C    = WIDTH'(MAX_COUNT);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    logic [WIDTH-1:0] out_r;
    logic [DIV_W-1:0] presc;
    logic             tick_r;
    logic             tc_r;
    logic             pause;
    logic [WIDTH-1:0] step_out;
    logic             step_tc;
    logic [WIDTH-1:0] load_clamped;

`ifdef UPDOWN_TICK_COUNTER_PAUSE_EN
    assign pause = bus.pausa;
`else
    assign pause = 1'b0;
`endif

    assign load_clamped = (bus.load_value > MAX_C) ? MAX_C : bus.load_value;

    // An out-of-range count (> MAX_C) takes the at-limit branch when counting up.
    always_comb begin
        step_out = out_r;
        step_tc  = 1'b0;
        if (bus.updown) begin
            if (out_r < MAX_C) begin
                step_out = out_r + WIDTH'(1);
                step_tc  = (out_r == MAX_C - WIDTH'(1));
            end else if (bus.wrap_mode) begin
                step_out = '0;
                step_tc  = 1'b1;
            end
        end else begin
            if (out_r != '0) begin
                step_out = out_r - WIDTH'(1);
                step_tc  = (out_r == WIDTH'(1));
            end else if (bus.wrap_mode) begin
                step_out = MAX_C;
                step_tc  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !bus.activado) begin
            out_r  <= '0;
            presc  <= '0;
            tick_r <= 1'b0;
            tc_r   <= 1'b0;
        end else if (bus.load) begin
            out_r  <= load_clamped;
            presc  <= '0;
            tick_r <= 1'b0;
            tc_r   <= 1'b0;
        end else if (pause) begin
            tick_r <= 1'b0;
            tc_r   <= 1'b0;
        end else if (presc == DIV_LAST) begin
            presc  <= '0;
            out_r  <= step_out;
            tick_r <= 1'b1;
            tc_r   <= step_tc;
        end else begin
            presc  <= presc + DIV_W'(1);
            tick_r <= 1'b0;
            tc_r   <= 1'b0;
        end
    end

    assign bus.out     = out_r;
    assign bus.tick    = tick_r;
    assign bus.tc      = tc_r;
    assign bus.at_max  = (out_r == MAX_C);
    assign bus.at_zero = (out_r == '0);
endmodule
